param_cpu_core: RTL and testbench

- Parametrised multi-cycle accumulator/register CPU core; successor to the fixed 8-bit, 4-register, internal-RAM core.
- Generalises data width, address width and register count.
- Moves program/data memory behind an external req/ack port with wait states.
- Adds working JUMP_NEG (N/Z flags), a sticky HALTED state and an instruction-retire strobe.
- Sits between the top-level memory model and the debug/test harness.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_alu.sv | 26 ++
 rtl/param_cpu_core.sv | 179 +++++++++++++++++
 tb/tb_param_cpu_core.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Opcodes, FSM state encoding and sizing helpers for param_cpu_core.
// Rev     : 1.0
// ============================================================================
package cpu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_HALT     = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LOAD_B   = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LOAD_A   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_STORE_A  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_ADD      = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_SUB      = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_JUMP     = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_JUMP_NEG = 4'b1011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    function automatic int num_regs(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module : cpu_alu
// Combinational wrap-around ADD/SUB with sign and zero outputs.
// Rev    : 1.0
// ============================================================================
module cpu_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] result_o,
    output logic              neg_o,
    output logic              zero_o
);

    always_comb begin
        result_o = sub_i ? (a_i - b_i) : (a_i + b_i);
    end

    assign neg_o  = result_o[DATA_W-1];
    assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/param_cpu_core.sv
`default_nettype none
// ============================================================================
// Module : param_cpu_core
// Multi-cycle register CPU with req/ack memory port; CPU_PERF_CNT_EN adds
// cycle_cnt/instr_cnt counters.
// Rev    : 1.0
// ============================================================================
module param_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int REG_IDX_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              retire,
    output logic              flag_n,
    output logic              flag_z
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    localparam int NREGS = num_regs(REG_IDX_W);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     regs_q [NREGS];
    logic [DATA_W-1:0]     ir_q, opa_q, opb_q, result_q, mdr_q;
    logic [ADDR_W-1:0]     pc_q;
    logic                  req_q, req_d, we_q, we_d;
    logic                  retire_q, halted_q, flag_n_q, flag_z_q;

    logic [OPCODE_W-1:0]   opcode;
    logic [ADDR_W-1:0]     ir_addr;
    logic [REG_IDX_W-1:0]  rs1, rd;
    logic                  is_load, is_mem_op, is_alu, accept;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_n, alu_z, alu_sub;

    assign opcode    = ir_q[DATA_W-1 -: OPCODE_W];
    assign ir_addr   = ir_q[ADDR_W-1:0];
    assign rs1       = ir_q[2*REG_IDX_W-1:REG_IDX_W];
    assign rd        = ir_q[REG_IDX_W-1:0];
    assign is_load   = (opcode == OP_LOAD_A) || (opcode == OP_LOAD_B);
    assign is_mem_op = is_load || (opcode == OP_STORE_A);
    assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign alu_sub   = (opcode == OP_SUB);
    assign accept    = req_q && mem_ack;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (opa_q),
        .b_i      (opb_q),
        .sub_i    (alu_sub),
        .result_o (alu_res),
        .neg_o    (alu_n),
        .zero_o   (alu_z)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (accept) state_d = DECODE;
            DECODE:  state_d = (opcode == OP_HALT) ? HALTED : EXEC;
            EXEC:    state_d = MEM;
            MEM:     if (!is_mem_op || accept) state_d = WB;
            WB:      state_d = FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Request is a function of the next state, so it drops right after the
    // accepting edge and WB always separates a data access from the next fetch.
    always_comb begin
        req_d = (state_d == FETCH) || ((state_d == MEM) && is_mem_op);
        we_d  = (state_d == MEM) && (opcode == OP_STORE_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            pc_q     <= '0;
            ir_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            mdr_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            retire_q <= (state_d == WB);
            halted_q <= (state_d == HALTED);
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + ADDR_W'(1);
                    end
                end
                DECODE: begin
                    opa_q <= regs_q[rs1];
                    opb_q <= regs_q[rd];
                end
                EXEC: begin
                    if (is_alu) begin
                        result_q <= alu_res;
                        flag_n_q <= alu_n;
                        flag_z_q <= alu_z;
                    end
                    if ((opcode == OP_JUMP) || ((opcode == OP_JUMP_NEG) && flag_n_q)) begin
                        pc_q <= ir_addr;
                    end
                end
                MEM: begin
                    if (is_load && accept) mdr_q <= mem_rdata;
                end
                WB: begin
                    case (opcode)
                        OP_ADD, OP_SUB: regs_q[rd] <= result_q;
                        OP_LOAD_A:      regs_q[REG_IDX_W'(0)] <= mdr_q;
                        OP_LOAD_B:      regs_q[REG_IDX_W'(1)] <= mdr_q;
                        default:        ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = (state_q == FETCH) ? pc_q : ir_addr;
    assign mem_wdata = regs_q[REG_IDX_W'(0)];
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign retire    = retire_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;

`ifdef CPU_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != HALTED) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire_q)          instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_cpu_core.sv
`default_nettype none
// ============================================================================
// Module : tb_param_cpu_core
// Self-checking bench: directed program table plus random programs with
// random memory wait states, checked against an instruction-level model.
// ============================================================================
module tb_param_cpu_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_req, mem_we, mem_ack;
    logic [3:0] mem_addr, pc;
    logic [7:0] mem_wdata, mem_rdata;
    logic       halted, retire, flag_n, flag_z;
`ifdef CPU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    param_cpu_core #(.DATA_W(8), .ADDR_W(4), .REG_IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .halted    (halted),
        .retire    (retire),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
`ifdef CPU_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Memory seen by the core, and the instruction-level model's state.
    logic [7:0] tmem [16];
    logic [7:0] mmem [16];
    logic [7:0] mreg [4];
    logic [3:0] mpc;
    logic       mn, mz, mhalt;

    // Memory responder: 0 = zero wait, 1 = random 0..3 waits, 2 = ack only the first request.
    int         mode;
    logic       ack_pend, waiting;
    int         wait_left, txn_cnt, cyc, last_ret, retires;
    logic [3:0] sv_addr, first_addr;
    logic       sv_we, seen_halt;
    logic [7:0] sv_wdata;

    typedef struct {
        logic [127:0] prog;
        int           nret;
        logic [3:0]   exp_pc;
        logic         exp_n;
        logic         exp_z;
        logic         exp_halted;
        logic [7:0]   exp_m13;
    } vec_t;

    vec_t vec [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] ir, res;
        logic [3:0] op, a;
        logic [1:0] s1, s2;
        ir  = mmem[mpc];
        mpc = mpc + 4'd1;
        op  = ir[7:4];
        a   = ir[3:0];
        s1  = ir[3:2];
        s2  = ir[1:0];
        case (op)
            4'h0: mhalt = 1'b1;
            4'h1: mreg[1] = mmem[a];
            4'h2: mreg[0] = mmem[a];
            4'h4: mmem[a] = mreg[0];
            4'h8, 4'h9: begin
                res = (op == 4'h8) ? mreg[s1] + mreg[s2] : mreg[s1] - mreg[s2];
                mreg[s2] = res;
                mn = res[7];
                mz = (res == 8'h00);
            end
            4'hA: mpc = a;
            4'hB: if (mn) mpc = a;
            default: ;
        endcase
    endtask

    task automatic load_prog(input logic [127:0] p);
        for (int i = 0; i < 16; i++) tmem[i] = p[8*i +: 8];
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        ack_pend  = 1'b0;
        waiting   = 1'b0;
        txn_cnt   = 0;
        seen_halt = 1'b0;
        retires   = 0;
        last_ret  = -1;
        cyc       = 0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        for (int i = 0; i < 16; i++) mmem[i] = tmem[i];
        mpc = 4'd0; mn = 1'b0; mz = 1'b0; mhalt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    mem_req, 0);
        check({tag, "_we"},     mem_we,  0);
        check({tag, "_pc"},     pc,      0);
        check({tag, "_halted"}, halted,  0);
        check({tag, "_retire"}, retire,  0);
        check({tag, "_n"},      flag_n,  0);
        check({tag, "_z"},      flag_z,  0);
`ifdef CPU_PERF_CNT_EN
        check({tag, "_cyc"},    cycle_cnt, 0);
        check({tag, "_icnt"},   instr_cnt, 0);
`endif
    endtask

    // One clock: serve the memory port, then score retires/halt against the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ack_pend) begin
            if (sv_we) tmem[sv_addr] = sv_wdata;
            ack_pend = 1'b0;
            mem_ack  = 1'b0;
            check("req_drop_after_ack", mem_req, 0);
        end else if (mem_req) begin
            if (!waiting) begin
                waiting  = 1'b1;
                sv_addr  = mem_addr;
                sv_we    = mem_we;
                sv_wdata = mem_wdata;
                if (txn_cnt == 0) first_addr = mem_addr;
                case (mode)
                    0:       wait_left = 0;
                    1:       wait_left = $urandom_range(0, 3);
                    default: wait_left = (txn_cnt == 0) ? 0 : 1000000;
                endcase
                txn_cnt++;
            end else begin
                check("req_stable", {mem_addr, mem_we, mem_wdata}, {sv_addr, sv_we, sv_wdata});
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = tmem[sv_addr];
                ack_pend  = 1'b1;
                waiting   = 1'b0;
            end else begin
                wait_left--;
            end
        end else if (waiting) begin
            check("req_held_while_waiting", mem_req, 1);
            waiting = 1'b0;
        end

        if (retire) begin
            retires++;
            if (mode == 0 && last_ret >= 0) check("retire_gap", cyc - last_ret, 5);
            last_ret = cyc;
            model_step();
            check("retire_not_halt", mhalt, 0);
            check("retire_pc", pc, mpc);
            check("retire_flag_n", flag_n, mn);
            check("retire_flag_z", flag_z, mz);
        end
        if (halted && !seen_halt) begin
            seen_halt = 1'b1;
            model_step();
            check("halt_is_halt_insn", mhalt, 1);
            check("halt_pc", pc, mpc);
        end
    endtask

    task automatic run(input int nret);
        int budget;
        budget = 2000;
        while (!(retires >= nret || seen_halt) && budget > 0) begin
            tick();
            budget--;
        end
        check("run_timeout", (budget == 0), 0);
`ifdef CPU_PERF_CNT_EN
        check("instr_cnt", instr_cnt, retires);
`endif
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) check($sformatf("%s_mem%0d", tag, i), tmem[i], mmem[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [13];
        logic [127:0] rp;

        mem_ack = 1'b0; mem_rdata = 8'h00; mode = 0;
        // Loop: r0=1,r1=1, then r0=r1+r0 repeatedly (2,3,4), PC 0,1,2,3,2,3..
        vec[0] = '{128'h01_01_00_00_00_00_00_00_00_00_00_00_A2_84_1F_2E, 8,   4'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        // r1 = 1-3 = 0xFE sets N, JUMP_NEG taken to 5, store r0=1 to M13, HALT at 6.
        vec[1] = '{128'h03_01_00_00_00_00_00_00_00_00_4D_00_B5_91_1F_2E, 100, 4'd7, 1'b1, 1'b0, 1'b1, 8'h01};
        // r0-r0 = 0 sets Z, JUMP_NEG falls through, store 0x2A to M13, HALT at 5.
        vec[2] = '{128'h00_2A_00_00_00_00_00_00_00_00_00_4D_2E_B6_90_2E, 100, 4'd6, 1'b0, 1'b1, 1'b1, 8'h2A};
        // 0x7F+1 overflows to 0x80 (N set), store to M13, HALT at 4.
        vec[3] = '{128'h01_7F_00_00_00_00_00_00_00_00_00_00_4D_84_1F_2E, 100, 4'd5, 1'b1, 1'b0, 1'b1, 8'h80};
        // JUMP 15; fetch at 15 wraps PC to 0.
        vec[4] = '{128'h2E_00_00_00_00_00_00_00_00_00_00_00_00_00_00_AF, 4,   4'd0, 1'b0, 1'b0, 1'b0, 8'h00};

        load_prog(vec[0].prog);
        rst_n = 1'b0;
        #3;
        check_reset_outputs("reset");

        for (int v = 0; v < 5; v++) begin
            load_prog(vec[v].prog);
            mode = 0;
            do_reset();
            run(vec[v].nret);
            check($sformatf("v%0d_pc", v),     pc,        vec[v].exp_pc);
            check($sformatf("v%0d_n", v),      flag_n,    vec[v].exp_n);
            check($sformatf("v%0d_z", v),      flag_z,    vec[v].exp_z);
            check($sformatf("v%0d_halted", v), halted,    vec[v].exp_halted);
            check($sformatf("v%0d_m13", v),    tmem[13],  vec[v].exp_m13);
            check($sformatf("v%0d_first", v),  first_addr, 0);
        end

        // HALT is absorbing: no requests, no retires; reset restarts from 0.
        begin
            int activity;
            load_prog(vec[1].prog);
            mode = 0;
            do_reset();
            run(100);
            activity = 0;
            repeat (20) begin
                tick();
                if (mem_req || retire || !halted) activity++;
            end
            check("halt_quiet", activity, 0);
            do_reset();
            run(100);
            check("restart_first_addr", first_addr, 0);
            check("restart_halted", halted, 1);
            check("restart_pc", pc, 7);
        end

        // Reset dropped while a data read is stalled.
        load_prog(vec[2].prog);
        mode = 2;
        do_reset();
        repeat (10) tick();
        check("stall_req", mem_req, 1);
        check("stall_addr", mem_addr, 14);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreq");
        mode = 0;
        do_reset();
        run(100);
        check("midreq_first_addr", first_addr, 0);
        check("midreq_pc", pc, 6);
        check("midreq_m13", tmem[13], 8'h2A);

        // Random programs with random wait states against the model.
        ops = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h9, 4'h8, 4'h9, 4'hA, 4'hB, 4'h3, 4'h0};
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                rp[8*i +: 8] = {ops[$urandom_range(0, 12)], 4'($urandom_range(0, 15))};
            end
            load_prog(rp);
            mode = 1;
            do_reset();
            run(25);
            check_mem($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
